// File: rtl/card_board_ctrl_pkg.sv
// Shared types and constants for the card memory-game board controller.
// Holds the per-card state encoding, controller FSM states and LFSR step helper.
// No ports; imported by card_board_ctrl and lfsr16.
package card_board_ctrl_pkg;

    typedef enum logic [1:0] {
        CARD_DOWN    = 2'd0,
        CARD_UP      = 2'd1,
        CARD_MATCHED = 2'd2
    } card_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_PICK1,
        S_PICK2,
        S_CHECK,
        S_SHOW,
        S_DONE
    } fsm_e;

    localparam int N_PAIRS = 8;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 (maximal length).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/card_board_ctrl_lfsr16.sv
// 16-bit free-running Galois LFSR used as the shuffle random source.
// Ports: clk, rst (sync active-high, loads SEED), q = current LFSR value.
// Steps every cycle out of reset; never reaches 0 for a nonzero SEED.
module lfsr16
    import card_board_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = lfsr_next(q_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/card_board_ctrl.sv
// Game-state producer for the 16-card memory game: deck build/shuffle, cursor,
// pair flipping, match checking, two-player scoring and timed hiding of mismatches.
// Ports: clk/rst (sync), start/btn_move/btn_sel pulses in; packed per-card state
// (2b each) and symbol_id (4b each), cursor hi, player, score0/1, busy, game_over out.
module card_board_ctrl
    import card_board_ctrl_pkg::*;
#(
    parameter int          N_CARDS     = 16,
    parameter int          SHOW_CYCLES = 25_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter bit          SHUFFLE_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn_move,
    input  logic        btn_sel,
    output logic [31:0] state,
    output logic [63:0] symbol_id,
    output logic [3:0]  hi,
    output logic        player,
    output logic [3:0]  score0,
    output logic [3:0]  score1,
    output logic        busy,
    output logic        game_over
);

    localparam int TW = $clog2(SHOW_CYCLES + 1);

    fsm_e          fsm_q, fsm_d;
    card_state_e   st_q  [N_CARDS];
    card_state_e   st_d  [N_CARDS];
    logic [3:0]    sym_q [N_CARDS];
    logic [3:0]    sym_d [N_CARDS];
    logic [3:0]    hi_q, hi_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic [3:0]    k_q, k_d;
    logic [3:0]    score0_q, score0_d;
    logic [3:0]    score1_q, score1_d;
    logic          player_q, player_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    score_sum;

    logic [15:0]   lfsr_q;
    logic [3:0]    j;
    logic          unused_lfsr_hi;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign j              = lfsr_q[3:0];
    assign unused_lfsr_hi = ^lfsr_q[15:4];

    always_comb begin
        fsm_d     = fsm_q;
        st_d      = st_q;
        sym_d     = sym_q;
        hi_d      = hi_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        score0_d  = score0_q;
        score1_d  = score1_q;
        player_d  = player_q;
        timer_d   = timer_q;
        score_sum = 5'd0;

        // start pre-empts everything; the INIT cycle then rebuilds the board.
        if (start) begin
            fsm_d = S_INIT;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                end

                S_INIT: begin
                    for (int i = 0; i < N_CARDS; i++) begin
                        sym_d[i] = 4'(i >> 1);
                        st_d[i]  = CARD_DOWN;
                    end
                    hi_d     = 4'd0;
                    player_d = 1'b0;
                    score0_d = 4'd0;
                    score1_d = 4'd0;
                    k_d      = 4'd15;
                    fsm_d    = SHUFFLE_EN ? S_SHUFFLE : S_PICK1;
                end

                // Fisher-Yates: out-of-range draws are simply retried next cycle
                // rather than reduced modulo k, which keeps the permutation unbiased.
                S_SHUFFLE: begin
                    if (j <= k_q) begin
                        sym_d[k_q] = sym_q[j];
                        sym_d[j]   = sym_q[k_q];
                        if (k_q == 4'd1) begin
                            fsm_d = S_PICK1;
                        end else begin
                            k_d = k_q - 4'd1;
                        end
                    end
                end

                // A select press always consumes the cycle, so a simultaneous
                // move is dropped even when the select itself is ignored.
                S_PICK1, S_PICK2: begin
                    if (btn_sel) begin
                        if (st_q[hi_q] == CARD_DOWN) begin
                            st_d[hi_q] = CARD_UP;
                            if (fsm_q == S_PICK1) begin
                                a_d   = hi_q;
                                fsm_d = S_PICK2;
                            end else begin
                                b_d   = hi_q;
                                fsm_d = S_CHECK;
                            end
                        end
                    end else if (btn_move) begin
                        hi_d = hi_q + 4'd1;
                    end
                end

                S_CHECK: begin
                    if (sym_q[a_q] == sym_q[b_q]) begin
                        st_d[a_q] = CARD_MATCHED;
                        st_d[b_q] = CARD_MATCHED;
                        if (player_q) begin
                            score1_d = score1_q + 4'd1;
                        end else begin
                            score0_d = score0_q + 4'd1;
                        end
                        score_sum = 5'(score0_d) + 5'(score1_d);
                        fsm_d     = (score_sum == 5'(N_PAIRS)) ? S_DONE : S_PICK1;
                    end else begin
                        timer_d = TW'(SHOW_CYCLES - 1);
                        fsm_d   = S_SHOW;
                    end
                end

                S_SHOW: begin
                    if (timer_q == '0) begin
                        st_d[a_q] = CARD_DOWN;
                        st_d[b_q] = CARD_DOWN;
                        player_d  = ~player_q;
                        fsm_d     = S_PICK1;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end

                S_DONE: begin
                end

                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= S_IDLE;
            for (int i = 0; i < N_CARDS; i++) begin
                st_q[i]  <= CARD_DOWN;
                sym_q[i] <= 4'd0;
            end
            hi_q     <= 4'd0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            k_q      <= 4'd0;
            score0_q <= 4'd0;
            score1_q <= 4'd0;
            player_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            fsm_q    <= fsm_d;
            st_q     <= st_d;
            sym_q    <= sym_d;
            hi_q     <= hi_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            player_q <= player_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state     = '0;
        symbol_id = '0;
        for (int i = 0; i < N_CARDS; i++) begin
            state[2*i +: 2]     = st_q[i];
            symbol_id[4*i +: 4] = sym_q[i];
        end
    end

    assign hi        = hi_q;
    assign player    = player_q;
    assign score0    = score0_q;
    assign score1    = score1_q;
    assign busy      = (fsm_q == S_INIT) || (fsm_q == S_SHUFFLE) ||
                       (fsm_q == S_CHECK) || (fsm_q == S_SHOW);
    assign game_over = (fsm_q == S_DONE);

endmodule

// File: tb/tb_card_board_ctrl.sv
// Directed bench for card_board_ctrl: unshuffled instance for gameplay, shuffled
// instance for deck permutation. Expected values are queued when stimulus is
// driven and popped when the DUT output is sampled (#1 after the clock edge).
module tb_card_board_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, mv0 = 1'b0, sel0 = 1'b0;
    logic [31:0] state0;
    logic [63:0] sym0;
    logic [3:0]  hi0, sc0_0, sc1_0;
    logic        pl0, busy0, over0;

    logic        start1 = 1'b0, mv1 = 1'b0, sel1 = 1'b0;
    logic [31:0] state1;
    logic [63:0] sym1;
    logic [3:0]  hi1, sc0_1, sc1_1;
    logic        pl1, busy1, over1;

    card_board_ctrl #(.N_CARDS(16), .SHOW_CYCLES(4), .LFSR_SEED(16'hACE1), .SHUFFLE_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .btn_move(mv0), .btn_sel(sel0),
        .state(state0), .symbol_id(sym0), .hi(hi0), .player(pl0),
        .score0(sc0_0), .score1(sc1_0), .busy(busy0), .game_over(over0));

    card_board_ctrl #(.N_CARDS(16), .SHOW_CYCLES(4), .LFSR_SEED(16'hACE1), .SHUFFLE_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .btn_move(mv1), .btn_sel(sel1),
        .state(state1), .symbol_id(sym1), .hi(hi1), .player(pl1),
        .score0(sc0_1), .score1(sc1_1), .busy(busy1), .game_over(over1));

    int checks = 0;
    int failures = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    // Model of the unshuffled board.
    logic [1:0] m_st [16];
    int         m_hi;
    int         m_sc0, m_sc1;
    logic       m_pl;

    task automatic expect_v(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_v(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%0h", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        expect_v(tag, exp);
        check_v(obs);
    endtask

    function automatic logic [63:0] pack_st();
        logic [63:0] r = '0;
        for (int i = 0; i < 16; i++) r[2*i +: 2] = m_st[i];
        return r;
    endfunction

    function automatic logic [63:0] plain_deck();
        logic [63:0] r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = 4'(i >> 1);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_st[i] = 2'd0;
        m_hi = 0; m_sc0 = 0; m_sc1 = 0; m_pl = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move();
        mv0 = 1'b1; tick(); mv0 = 1'b0;
        m_hi = (m_hi + 1) % 16;
    endtask

    task automatic sel();
        sel0 = 1'b1; tick(); sel0 = 1'b0;
    endtask

    task automatic goto_card(input int t);
        while (m_hi != t) move();
    endtask

    task automatic start_game();
        start0 = 1'b1; tick(); start0 = 1'b0;
        tick();
        model_clear();
    endtask

    // Flip cards 2p and 2p+1 (same symbol in the unshuffled deck) and resolve.
    task automatic match_pair(input int p, input string tag);
        goto_card(2 * p);
        m_st[2*p] = 2'd1;
        sel();
        move();
        m_st[2*p+1] = 2'd1;
        sel();
        m_st[2*p] = 2'd2; m_st[2*p+1] = 2'd2;
        if (m_pl) m_sc1++; else m_sc0++;
        expect_v({tag, "_state"}, pack_st());
        expect_v({tag, "_score"}, 64'({4'(m_sc1), 4'(m_sc0)}));
        tick();
        check_v(64'(state0));
        check_v(64'({sc1_0, sc0_0}));
    endtask

    initial begin
        int cnt [8];
        int budget;

        model_clear();
        tick(); tick();

        // Reset state
        chk("rst_state",  64'(state0), 64'd0);
        chk("rst_sym",    sym0,        64'd0);
        chk("rst_hi",     64'(hi0),    64'd0);
        chk("rst_player", 64'(pl0),    64'd0);
        chk("rst_scores", 64'({sc1_0, sc0_0}), 64'd0);
        chk("rst_flags",  64'({busy0, over0}), 64'd0);
        rst = 1'b0;

        // Start without shuffle: INIT is busy for one cycle
        start0 = 1'b1;
        expect_v("init_busy", 64'd1);
        tick(); start0 = 1'b0;
        check_v(64'(busy0));
        expect_v("pick_busy", 64'd0);
        tick();
        check_v(64'(busy0));
        model_clear();
        chk("init_deck",  sym0,        plain_deck());
        chk("init_state", 64'(state0), 64'd0);

        // Match cards 0/1 for player 0
        m_st[0] = 2'd1;
        sel();
        chk("flip0", 64'(state0), pack_st());
        move();
        m_st[1] = 2'd1;
        sel();
        chk("check_busy", 64'(busy0), 64'd1);
        tick();
        m_st[0] = 2'd2; m_st[1] = 2'd2; m_sc0 = 1;
        chk("match01_state",  64'(state0), pack_st());
        chk("match01_score0", 64'(sc0_0),  64'd1);
        chk("match01_player", 64'(pl0),    64'd0);

        // Mismatch cards 2 (sym 1) and 4 (sym 2); inputs during SHOW ignored
        goto_card(2); m_st[2] = 2'd1; sel();
        goto_card(4); m_st[4] = 2'd1; sel();
        tick();                                   // CHECK -> SHOW
        mv0 = 1'b1; sel0 = 1'b1; tick(); mv0 = 1'b0; sel0 = 1'b0;
        chk("show_hi",    64'(hi0),    64'(m_hi));
        chk("show_state", 64'(state0), pack_st());
        chk("show_busy",  64'(busy0),  64'd1);
        tick(); tick();
        chk("show_last_up", 64'(state0), pack_st());
        tick();
        m_st[2] = 2'd0; m_st[4] = 2'd0; m_pl = 1'b1;
        chk("hide_state",  64'(state0), pack_st());
        chk("hide_player", 64'(pl0),    64'd1);
        chk("hide_busy",   64'(busy0),  64'd0);

        // Re-selecting an UP card is ignored
        m_st[4] = 2'd1;
        sel();
        sel();
        chk("reselect_state", 64'(state0), pack_st());
        chk("reselect_busy",  64'(busy0),  64'd0);
        goto_card(5); m_st[5] = 2'd1; sel();
        tick();
        m_st[4] = 2'd2; m_st[5] = 2'd2; m_sc1 = 1;
        chk("match45_state",  64'(state0), pack_st());
        chk("match45_score1", 64'(sc1_0),  64'd1);

        // move + sel together: only the flip happens
        goto_card(6);
        mv0 = 1'b1; sel0 = 1'b1; tick(); mv0 = 1'b0; sel0 = 1'b0;
        m_st[6] = 2'd1;
        chk("movesel_hi",    64'(hi0),    64'd6);
        chk("movesel_state", 64'(state0), pack_st());
        move(); m_st[7] = 2'd1; sel(); tick();
        m_st[6] = 2'd2; m_st[7] = 2'd2; m_sc1 = 2;
        chk("match67_score1", 64'(sc1_0), 64'd2);

        // Cursor wrap
        goto_card(15);
        chk("hi_15", 64'(hi0), 64'd15);
        move();
        chk("hi_wrap", 64'(hi0), 64'd0);

        // Finish the game
        match_pair(1, "pair1");
        match_pair(4, "pair4");
        match_pair(5, "pair5");
        match_pair(6, "pair6");
        chk("not_over_7", 64'(over0), 64'd0);
        match_pair(7, "pair7");
        chk("game_over",   64'(over0), 64'd1);
        chk("score_total", 64'(sc0_0 + sc1_0), 64'd8);
        chk("done_busy",   64'(busy0), 64'd0);
        mv0 = 1'b1; tick(); mv0 = 1'b0;
        chk("done_move_ignored", 64'(hi0), 64'd15);

        // start during SHOW rebuilds the board
        start_game();
        match_pair(0, "restart_pair0");
        goto_card(2); sel();
        goto_card(4); sel();
        tick(); tick();                           // in SHOW
        chk("pre_restart_busy", 64'(busy0), 64'd1);
        start_game();
        chk("restart_state",  64'(state0), 64'd0);
        chk("restart_deck",   sym0,        plain_deck());
        chk("restart_scores", 64'({sc1_0, sc0_0}), 64'd0);
        chk("restart_hi",     64'(hi0),    64'd0);
        chk("restart_busy",   64'(busy0),  64'd0);

        // Reset mid-game
        m_st[0] = 2'd1; sel();
        move();
        chk("pre_rst_state", 64'(state0), pack_st());
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_state", 64'(state0), 64'd0);
        chk("midrst_sym",   sym0,        64'd0);
        chk("midrst_hi",    64'(hi0),    64'd0);
        chk("midrst_flags", 64'({busy0, over0, pl0}), 64'd0);

        // Shuffled instance: busy until PICK1, each symbol exactly twice
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("shuf_busy", 64'(busy1), 64'd1);
        budget = 0;
        while (busy1 && budget < 3000) begin
            tick();
            budget++;
        end
        chk("shuf_done", 64'(busy1), 64'd0);
        chk("shuf_state", 64'(state1), 64'd0);
        for (int s = 0; s < 8; s++) cnt[s] = 0;
        for (int i = 0; i < 16; i++) begin
            if (sym1[4*i +: 4] < 4'd8) cnt[sym1[4*i +: 4]]++;
        end
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("shuf_count_sym%0d", s), 64'(cnt[s]), 64'd2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
